fnd_scan_decoder: RTL and testbench
===================================

// Module: fnd_scan_decoder
// PURPOSE
//  Receive-side counterpart of the BIN->FND encoder. Samples a multiplexed, active-low
//  8-bit FND segment bus together with its digit-select lines. Converts each stable
//  pattern back to a 4-bit BCD digit and assembles one full display frame.
//  Used as a loopback/self-check monitor on the scanned display path, and as a
//  read-back source for the control logic.
// PARAMETERS
//  NUM_DIGITS      4   number of scanned digits (digit-select width)
//  STABLE_CYCLES   4   consecutive identical samples required before a digit is captured (>=1)
//  SEL_ACTIVE_LOW  1   1: i_digit_sel low selects a digit; 0: high selects
// PORTS
//  i_clk          in   1               system clock, all logic on rising edge
//  i_rst_n        in   1               asynchronous active-low reset
//  i_fndout       in   8               segment bus, active-low; bit7..bit1 = a..g, bit0 = dp
//  i_digit_sel    in   NUM_DIGITS      digit select; bit k = digit k (digit 0 = LS nibble)
//  o_bcd          out  4*NUM_DIGITS    last complete frame, digit k at [4k+3:4k]
//  o_dp           out  NUM_DIGITS      decimal-point state per digit in last frame (1 = lit)
//  o_valid        out  1               one-cycle pulse: o_bcd/o_dp/o_err just updated
//  o_err          out  1               last frame held >=1 illegal segment pattern
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): o_bcd=0, o_dp=0, o_valid=0, o_err=0.
//    Internal state also clears: sample regs, stability counter, shadow frame, digit mask, frame error.
//  - Input stage: i_fndout and i_digit_sel are registered once. All checks below use the registered values.
//  - Select normalisation: sel_act = SEL_ACTIVE_LOW ? ~sel : sel.
//    A sample is qualified only when sel_act is one-hot. Zero or multiple bits set = blanking.
//    During blanking the counter is held at 0 and nothing is captured.
//  - FSM per sample, two states:
//    * SETTLE: counter increments while {sel,seg} equals the previous sample and is qualified.
//      Any change reloads the counter to 1 (or 0 if unqualified).
//      When the counter reaches STABLE_CYCLES: capture and go to HELD.
//    * HELD: no further capture. Any change in {sel,seg} returns to SETTLE with counter=1,
//      so each dwell produces one capture. A change in seg alone also re-arms.
//  - Decode of seg_on = ~i_fndout[7:1] (a..g), exact match only:
//    0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//    5=1011011  6=1011111  7=1110010  8=1111111  9=1111011
//    Any other pattern (including all-off) stores 4'hF in the digit and sets the frame-error flag.
//  - dp_on = ~i_fndout[0], stored per digit independently of the decode.
//  - Capture writes the shadow nibble and dp for digit k and sets mask[k].
//    Recapturing a digit already in the mask overwrites its shadow value and does not complete the frame.
//  - Frame complete: when the capture sets the last missing mask bit.
//    Next cycle: o_bcd<=shadow, o_dp<=shadow_dp, o_err<=frame_err (incl. this capture), o_valid=1 for 1 cycle.
//    Mask and frame_err clear in the same cycle.
//  - Latency: stable input at pins to capture = 1 (input reg) + STABLE_CYCLES cycles.
//    Final capture to o_valid = 1 cycle.
//  - Outputs hold between frames. o_err is not sticky across frames.
//  - Reset mid-frame discards the partial frame. No o_valid is produced for it.
//  - Counter saturates at STABLE_CYCLES. Width = $clog2(STABLE_CYCLES+1).
// TESTING
//  1. Scan digits 0..3 with patterns for 1,2,3,4 (~8'b01100000 etc.), 8-cycle dwell, active-low select
//     -> one o_valid pulse, o_bcd=16'h4321, o_dp=0, o_err=0.
//  2. Digit 2 shows ~8'b00000010 (g only), others legal 5
//     -> o_bcd=16'h5F55, o_err=1. The next clean frame gives o_err=0.
//  3. Glitch: seg toggles after 3 cycles of dwell (STABLE_CYCLES=4)
//     -> no capture until 4 stable samples; the captured value is the post-glitch pattern.
//  4. i_digit_sel = 4'b1111 (none) and 4'b0011 (two) for 20 cycles
//     -> no capture, no o_valid, outputs unchanged.
//  5. Sequence 0,1,0,2,3 with digit0 changing 7->9 between visits
//     -> single o_valid after digit 3, nibble0=9.
//  6. Assert i_rst_n=0 after 2 of 4 digits captured, then release and scan full frame 9,8,7,6
//     -> all outputs 0 during reset; exactly one o_valid after release, o_bcd=16'h6789.

Source files
------------

// File: rtl/fnd_scan_decoder.sv
// Receive-side decoder for a scanned, active-low 7-segment bus: debounces each digit dwell,
// converts the segment pattern back to BCD and publishes one complete frame at a time.
module fnd_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_fndout,
    input  logic [NUM_DIGITS-1:0]   i_digit_sel,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [NUM_DIGITS-1:0]   o_dp,
    output logic                    o_valid,
    output logic                    o_err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {S_SETTLE, S_HELD} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_seg;
    logic [7:0]              r_prev_seg;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [NUM_DIGITS-1:0]   r_prev_sel;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_next;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic                    r_frame_err;
    logic                    r_frame_done;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;

    logic [NUM_DIGITS-1:0]   w_sel_act;
    logic                    w_qual;
    logic                    w_same;
    logic                    w_capture;
    logic [6:0]              w_seg_on;
    logic                    w_dp_on;
    logic [3:0]              w_dec_val;
    logic                    w_dec_err;
    logic [NUM_DIGITS-1:0]   w_cap_mask;
    logic [NUM_DIGITS-1:0]   w_mask_base;
    logic [NUM_DIGITS-1:0]   w_mask_next;
    logic                    w_err_next;
    logic                    w_complete;

    assign w_sel_act = (SEL_ACTIVE_LOW != 0) ? ~r_sel : r_sel;
    assign w_qual    = (w_sel_act != '0) && ((w_sel_act & (w_sel_act - 1'b1)) == '0);
    assign w_same    = (r_seg == r_prev_seg) && (r_sel == r_prev_sel);
    assign w_seg_on  = ~r_seg[7:1];
    assign w_dp_on   = ~r_seg[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg      <= '0;
            r_sel      <= '0;
            r_prev_seg <= '0;
            r_prev_sel <= '0;
            r_cnt      <= '0;
            r_state    <= S_SETTLE;
        end else begin
            r_seg      <= i_fndout;
            r_sel      <= i_digit_sel;
            r_prev_seg <= r_seg;
            r_prev_sel <= r_sel;
            r_cnt      <= w_cnt_next;
            r_state    <= w_state_next;
        end
    end

    // A change always restarts the dwell; HELD only suppresses repeat captures of an unchanged sample.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        if (!w_qual) begin
            w_cnt_next   = '0;
            w_state_next = S_SETTLE;
        end else begin
            if (!w_same) begin
                w_cnt_next   = CNT_ONE;
                w_state_next = S_SETTLE;
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_next = r_cnt + CNT_ONE;
            end
            if ((!w_same || r_state == S_SETTLE) && w_cnt_next == CNT_MAX) begin
                w_capture    = 1'b1;
                w_state_next = S_HELD;
            end
        end
    end

    always_comb begin
        w_dec_val = 4'hF;
        w_dec_err = 1'b0;
        case (w_seg_on)
            7'b1111110: w_dec_val = 4'd0;
            7'b0110000: w_dec_val = 4'd1;
            7'b1101101: w_dec_val = 4'd2;
            7'b1111001: w_dec_val = 4'd3;
            7'b0110011: w_dec_val = 4'd4;
            7'b1011011: w_dec_val = 4'd5;
            7'b1011111: w_dec_val = 4'd6;
            7'b1110010: w_dec_val = 4'd7;
            7'b1111111: w_dec_val = 4'd8;
            7'b1111011: w_dec_val = 4'd9;
            default:    w_dec_err = 1'b1;
        endcase
    end

    // The mask of a just-published frame is still set for one cycle; treat it as already cleared.
    assign w_cap_mask  = w_capture ? w_sel_act : '0;
    assign w_mask_base = r_frame_done ? '0 : r_mask;
    assign w_mask_next = w_mask_base | w_cap_mask;
    assign w_err_next  = (r_frame_done ? 1'b0 : r_frame_err) | (w_capture & w_dec_err);
    assign w_complete  = w_capture && ((w_mask_base & w_cap_mask) == '0) && (w_mask_next == '1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask       <= '0;
            r_frame_err  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_mask       <= w_mask_next;
            r_frame_err  <= w_err_next;
            r_frame_done <= w_complete;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_shadow[4*gi +: 4] <= 4'h0;
                r_shadow_dp[gi]     <= 1'b0;
            end else if (w_cap_mask[gi]) begin
                r_shadow[4*gi +: 4] <= w_dec_val;
                r_shadow_dp[gi]     <= w_dp_on;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bcd   <= '0;
            o_dp    <= '0;
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= r_frame_done;
            if (r_frame_done) begin
                o_bcd <= r_shadow;
                o_dp  <= r_shadow_dp;
                o_err <= r_frame_err;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed scan sequences for fnd_scan_decoder; expected frames are queued by the stimulus
// thread and checked by an independent monitor on every o_valid pulse.
module tb_fnd_scan_decoder;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_fndout = 8'hFF;
    logic [3:0]  i_digit_sel = 4'hF;
    logic [15:0] o_bcd;
    logic [3:0]  o_dp;
    logic        o_valid;
    logic        o_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] last_bcd;
    logic        last_err;

    fnd_scan_decoder #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(4),
        .SEL_ACTIVE_LOW(1)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_fndout(i_fndout),
        .i_digit_sel(i_digit_sel),
        .o_bcd(o_bcd),
        .o_dp(o_dp),
        .o_valid(o_valid),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %0h", name, act);
        end
    endfunction

    // Active-low bus image of a decimal digit (a..g on bits 7..1, dp on bit 0).
    function automatic logic [7:0] fnd(int d, bit dp);
        logic [6:0] s;
        case (d)
            0: s = 7'b1111110;
            1: s = 7'b0110000;
            2: s = 7'b1101101;
            3: s = 7'b1111001;
            4: s = 7'b0110011;
            5: s = 7'b1011011;
            6: s = 7'b1011111;
            7: s = 7'b1110010;
            8: s = 7'b1111111;
            9: s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return ~{s, dp};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic show(int k, logic [7:0] pat, int dwell);
        logic [3:0] one;
        one = 4'b0001;
        i_digit_sel = ~(one << k);
        i_fndout    = pat;
        tick(dwell);
    endtask

    task automatic blank(int n);
        i_digit_sel = 4'hF;
        tick(n);
    endtask

    task automatic scan(int k, logic [7:0] pat);
        show(k, pat, 8);
        blank(2);
    endtask

    task automatic expect_frame(logic [15:0] bcd, logic [3:0] dp, logic err);
        exp_t e;
        e.bcd = bcd;
        e.dp  = dp;
        e.err = err;
        sb_q.push_back(e);
        last_bcd = bcd;
        last_err = err;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: %0d frame(s) outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end else begin
            $display("[TB] ok   %s: frame queue drained", name);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_valid) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_valid: got o_valid=1 bcd=%0h, expected no frame", o_bcd);
            end else begin
                mon_e = sb_q.pop_front();
                check("frame_bcd", 32'(o_bcd), 32'(mon_e.bcd));
                check("frame_dp", 32'(o_dp), 32'(mon_e.dp));
                check("frame_err", 32'(o_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        last_bcd = 16'h0;
        last_err = 1'b0;
        #23;
        check("reset_bcd", 32'(o_bcd), 32'h0);
        check("reset_dp", 32'(o_dp), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_err", 32'(o_err), 32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick(2);

        // 1: plain frame 4321
        expect_frame(16'h4321, 4'b0000, 1'b0);
        scan(0, fnd(1, 0));
        scan(1, fnd(2, 0));
        scan(2, fnd(3, 0));
        scan(3, fnd(4, 0));
        drain("t1_frame");

        // 2: illegal g-only pattern on digit 2, then a clean frame
        expect_frame(16'h5F55, 4'b0000, 1'b1);
        scan(0, fnd(5, 0));
        scan(1, fnd(5, 0));
        scan(2, 8'b11111101);
        scan(3, fnd(5, 0));
        drain("t2_err_frame");
        expect_frame(16'h0808, 4'b0000, 1'b0);
        scan(0, fnd(8, 0));
        scan(1, fnd(0, 0));
        scan(2, fnd(8, 0));
        scan(3, fnd(0, 0));
        drain("t2_clean_frame");

        // 3: short 7 on the completing digit must not capture; the following 6 does
        expect_frame(16'h6321, 4'b0000, 1'b0);
        scan(0, fnd(1, 0));
        scan(1, fnd(2, 0));
        scan(2, fnd(3, 0));
        show(3, fnd(7, 0), 3);
        show(3, fnd(6, 0), 8);
        blank(2);
        drain("t3_glitch");

        // 4: blanking with no select and with two selects
        i_fndout = fnd(8, 0);
        blank(20);
        i_digit_sel = 4'b0011;
        tick(20);
        blank(2);
        check("t4_bcd_hold", 32'(o_bcd), 32'(last_bcd));
        check("t4_err_hold", 32'(o_err), 32'(last_err));

        // 5: digit 0 revisited (7 -> 9); digit 1 has its dp lit
        expect_frame(16'h3219, 4'b0010, 1'b0);
        scan(0, fnd(7, 0));
        scan(1, fnd(1, 1));
        scan(0, fnd(9, 0));
        scan(2, fnd(2, 0));
        scan(3, fnd(3, 0));
        drain("t5_revisit");

        // 6: reset discards a half frame
        scan(0, fnd(5, 0));
        scan(1, fnd(5, 0));
        i_rst_n = 1'b0;
        #2;
        check("t6_rst_bcd", 32'(o_bcd), 32'h0);
        check("t6_rst_dp", 32'(o_dp), 32'h0);
        check("t6_rst_valid", 32'(o_valid), 32'h0);
        check("t6_rst_err", 32'(o_err), 32'h0);
        tick(3);
        i_rst_n = 1'b1;
        tick(1);
        expect_frame(16'h6789, 4'b0000, 1'b0);
        scan(0, fnd(9, 0));
        scan(1, fnd(8, 0));
        scan(2, fnd(7, 0));
        scan(3, fnd(6, 0));
        drain("t6_after_reset");
        blank(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
